// File: rtl/uart_tx_serializer.sv
// UART transmit stage: pops one byte at a time from the upstream FIFO and
// shifts it out as start, data (LSB first), optional parity and stop bit(s).
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int                 CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]         DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]         STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit                 HAS_PARITY = (PARITY == 1) || (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 bit_tick;
    logic                 frame_start;
    logic [DATA_BITS-1:0] load_bits;

    assign bit_tick    = (baud_cnt == CNT_LAST);
    assign frame_start = tx_en && !fifo_empty;
    assign load_bits   = fifo_data[DATA_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every non-idle state lasts whole bit times; bit_idx counts bits within DATA and STOP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = START;
            START:   if (bit_tick) state_next = DATA;
            DATA: begin
                if (bit_tick && (bit_idx == DATA_LAST)) begin
                    state_next = HAS_PARITY ? PAR_BIT : STOP;
                end
            end
            PAR_BIT: if (bit_tick) state_next = STOP;
            STOP: begin
                if (bit_tick && (bit_idx == STOP_LAST)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            START:   tx   = 1'b0;
            DATA:    tx   = shift_reg[0];
            PAR_BIT: tx   = parity_bit;
            default: tx   = 1'b1;
        endcase
    end

    // The FIFO head is only looked at in IDLE, so the pop issued here has a
    // whole frame to take effect before the next sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            fifo_rd_en <= (state == IDLE) && frame_start;
            tx_done    <= (state == STOP) && (state_next == IDLE);
            if (state == IDLE) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                if (frame_start) begin
                    shift_reg  <= load_bits;
                    parity_bit <= (PARITY == 1) ? ~^load_bits : ^load_bits;
                end
            end else if (bit_tick) begin
                baud_cnt <= '0;
                bit_idx  <= (state_next != state) ? 3'd0 : bit_idx + 3'd1;
                if (state == DATA) begin
                    shift_reg <= shift_reg >> 1;
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: five configurations share one FIFO model and a
// frame-level reference model; one instance is selected at a time.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [2:0] sel = 3'd0;

    logic [7:0] mem [16];
    logic [4:0] wr_ptr = '0;
    logic [4:0] rd_ptr = '0;
    logic       fifo_empty_raw;
    logic [7:0] fifo_data;

    logic [4:0] fe_v;
    logic [4:0] rd_v;
    logic [4:0] tx_v;
    logic [4:0] busy_v;
    logic [4:0] done_v;
    logic       rd_s, tx_s, busy_s, done_s;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pop_count = 0;
    int done_count = 0;
    bit check_on = 1'b0;

    int cfg_bits [5] = '{8, 8, 8, 7, 8};
    int cfg_par  [5] = '{0, 1, 2, 0, 3};
    int cfg_stop [5] = '{1, 2, 1, 1, 1};

    bit m_active = 1'b0;
    bit m_pop = 1'b0;
    bit m_done = 1'b0;
    int m_elapsed = 0;
    int m_len = 0;
    bit m_bits [16];

    always #5 clk = ~clk;

    assign fifo_empty_raw = (wr_ptr == rd_ptr);
    assign fifo_data      = mem[rd_ptr[3:0]];

    assign fe_v[0] = (sel != 3'd0) || fifo_empty_raw;
    assign fe_v[1] = (sel != 3'd1) || fifo_empty_raw;
    assign fe_v[2] = (sel != 3'd2) || fifo_empty_raw;
    assign fe_v[3] = (sel != 3'd3) || fifo_empty_raw;
    assign fe_v[4] = (sel != 3'd4) || fifo_empty_raw;

    assign rd_s   = rd_v[sel];
    assign tx_s   = tx_v[sel];
    assign busy_s = busy_v[sel];
    assign done_s = done_v[sel];

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe_v[0]), .fifo_data(fifo_data),
        .fifo_rd_en(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe_v[1]), .fifo_data(fifo_data),
        .fifo_rd_en(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_c (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe_v[2]), .fifo_data(fifo_data),
        .fifo_rd_en(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7)) dut_d (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe_v[3]), .fifo_data(fifo_data),
        .fifo_rd_en(rd_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(3)) dut_e (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe_v[4]), .fifo_data(fifo_data),
        .fifo_rd_en(rd_v[4]), .tx(tx_v[4]), .busy(busy_v[4]), .tx_done(done_v[4]));

    always @(posedge clk) begin
        if (rd_s) rd_ptr <= rd_ptr + 5'd1;
        if (rd_s) pop_count <= pop_count + 1;
        if (done_s) done_count <= done_count + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // The whole frame is laid out as a list of line levels, one per bit time.
    task automatic buildFrame(input logic [7:0] d);
        int n;
        int ones;
        n = 0;
        ones = 0;
        m_bits[n] = 1'b0;
        n++;
        for (int i = 0; i < cfg_bits[sel]; i++) begin
            m_bits[n] = d[i];
            n++;
            if (d[i]) ones++;
        end
        if (cfg_par[sel] == 1) begin
            m_bits[n] = (ones % 2 == 0);
            n++;
        end else if (cfg_par[sel] == 2) begin
            m_bits[n] = (ones % 2 == 1);
            n++;
        end
        for (int i = 0; i < cfg_stop[sel]; i++) begin
            m_bits[n] = 1'b1;
            n++;
        end
        m_len = n * CPB;
    endtask

    always @(posedge clk) begin
        cyc++;
        m_pop  = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_active  = 1'b0;
            m_elapsed = 0;
        end else if (m_active) begin
            m_elapsed++;
            if (m_elapsed == m_len) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (tx_en && !fifo_empty_raw) begin
            buildFrame(fifo_data);
            m_active  = 1'b1;
            m_elapsed = 0;
            m_pop     = 1'b1;
        end
    end

    always @(posedge clk) begin
        logic exp_tx;
        #1;
        if (check_on) begin
            exp_tx = m_active ? m_bits[m_elapsed / CPB] : 1'b1;
            checkOutput("model_tx", {31'd0, tx_s}, {31'd0, exp_tx});
            checkOutput("model_busy", {31'd0, busy_s}, {31'd0, m_active});
            checkOutput("model_rd_en", {31'd0, rd_s}, {31'd0, m_pop});
            checkOutput("model_tx_done", {31'd0, done_s}, {31'd0, m_done});
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic resetDut(input logic [2:0] s);
        @(negedge clk);
        rst    = 1'b1;
        tx_en  = 1'b0;
        sel    = s;
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitRise(output int c);
        bit prev;
        bit seen;
        prev = busy_s;
        seen = 1'b0;
        c = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (busy_s && !prev) begin
                seen = 1'b1;
                c = cyc;
            end
            prev = busy_s;
        end
        if (!seen) checkOutput("busy_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (!busy_s) seen = 1'b1;
        end
        if (!seen) checkOutput("busy_fall_timeout", 32'd0, 32'd1);
    endtask

    // Samples the line in the middle of each bit and times tx_done/busy from the start edge.
    task automatic captureFrame(input int n_bits, output logic [15:0] cap,
                                output int done_at, output int busy_cnt);
        int c;
        cap = '0;
        done_at = -1;
        busy_cnt = 0;
        waitRise(c);
        for (int t = 0; t < n_bits * CPB + 4; t++) begin
            if ((t % CPB == 2) && (t / CPB < n_bits)) cap[t / CPB] = tx_s;
            if (busy_s) busy_cnt++;
            if (done_s && done_at < 0) done_at = t;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic runLiteral(input logic [2:0] s, input logic [7:0] b, input int n_bits,
                              input logic [15:0] exp_cap, input string name);
        logic [15:0] cap;
        int done_at;
        int busy_cnt;
        resetDut(s);
        applyStimulus(b);
        tx_en = 1'b1;
        captureFrame(n_bits, cap, done_at, busy_cnt);
        checkOutput({name, "_bits"}, {16'd0, cap}, {16'd0, exp_cap});
        checkOutput({name, "_done_cycle"}, done_at, n_bits * CPB);
        checkOutput({name, "_busy_cycles"}, busy_cnt, n_bits * CPB);
    endtask

    initial begin
        logic [15:0] cap;
        int done_at, busy_cnt, p0, d0, c1, c2;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", {31'd0, tx_s}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy_s}, 32'd0);
        checkOutput("reset_rd_en", {31'd0, rd_s}, 32'd0);
        checkOutput("reset_tx_done", {31'd0, done_s}, 32'd0);
        @(negedge clk);
        check_on = 1'b1;
        rst = 1'b0;

        $display("[TB] single frame 0xA5");
        resetDut(3'd0);
        applyStimulus(8'hA5);
        p0 = pop_count;
        tx_en = 1'b1;
        captureFrame(10, cap, done_at, busy_cnt);
        checkOutput("a5_bits", {16'd0, cap}, 32'h34A);
        checkOutput("a5_done_cycle", done_at, 40);
        checkOutput("a5_busy_cycles", busy_cnt, 40);
        repeat (5) @(posedge clk);
        checkOutput("a5_pops", pop_count - p0, 1);

        $display("[TB] back-to-back 0x55, 0x0F");
        resetDut(3'd0);
        applyStimulus(8'h55);
        applyStimulus(8'h0F);
        p0 = pop_count;
        tx_en = 1'b1;
        waitRise(c1);
        waitIdle();
        checkOutput("gap_tx", {31'd0, tx_s}, 32'd1);
        waitRise(c2);
        checkOutput("b2b_period", c2 - c1, 41);
        repeat (50) @(posedge clk);
        checkOutput("b2b_pops", pop_count - p0, 2);

        $display("[TB] parity and data-width configurations");
        runLiteral(3'd1, 8'h07, 12, 16'hC0E, "odd_2stop_07");
        runLiteral(3'd2, 8'h01, 11, 16'h602, "even_01");
        runLiteral(3'd3, 8'hFF, 9, 16'h1FE, "data7_FF");
        runLiteral(3'd4, 8'h33, 10, 16'h266, "par3_33");

        $display("[TB] tx_en dropped mid-frame");
        resetDut(3'd0);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        p0 = pop_count;
        tx_en = 1'b1;
        waitRise(c1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        tx_en = 1'b0;
        waitIdle();
        repeat (20) @(posedge clk);
        #2;
        checkOutput("hold_pops", pop_count - p0, 1);
        checkOutput("hold_busy", {31'd0, busy_s}, 32'd0);
        @(negedge clk);
        tx_en = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("restart_busy", {31'd0, busy_s}, 32'd1);
        checkOutput("restart_tx", {31'd0, tx_s}, 32'd0);
        repeat (3) @(posedge clk);
        checkOutput("restart_pops", pop_count - p0, 2);
        waitIdle();

        $display("[TB] reset during data bit 3");
        resetDut(3'd0);
        applyStimulus(8'h3C);
        applyStimulus(8'h5A);
        p0 = pop_count;
        d0 = done_count;
        tx_en = 1'b1;
        waitRise(c1);
        repeat (17) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("rst_mid_tx", {31'd0, tx_s}, 32'd1);
        checkOutput("rst_mid_busy", {31'd0, busy_s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        waitRise(c2);
        checkOutput("rst_mid_no_done", done_count - d0, 0);
        waitIdle();
        repeat (3) @(posedge clk);
        checkOutput("rst_mid_pops", pop_count - p0, 2);
        checkOutput("rst_mid_done_after", done_count - d0, 1);

        tx_en = 1'b0;
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
